// File: rtl/bist_pkg.sv
// Shared types and constants for the cell BIST controller family:
// sequencer states, LFSR/MISR widths and their feedback polynomials.
package bist_pkg;

    localparam int LFSR_W = 8;
    localparam int SIG_W  = 16;

    localparam logic [SIG_W-1:0]  MISR_POLY = 16'h1021;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // Prefixed literals keep the names clear of the SEED parameter and DONE port.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_DONE
    } bist_state_e;

    // Fibonacci shift-left step for x^8+x^6+x^5+x^4+1 (taps on bits 7,5,4,3).
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register with synchronous clear and enable.
// sig_next is exported so a controller can judge the final signature on the same edge.
module bist_misr
    import bist_pkg::*;
#(
    parameter int RSP_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [RSP_W-1:0] rsp,
    output logic [SIG_W-1:0] sig,
    output logic [SIG_W-1:0] sig_next
);

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                 ^ SIG_W'(rsp);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST sequencer for a combinational cell: LFSR stimulus, MISR compaction of the
// response, and a final signature compare against EXP_SIG.
module cell_bist_ctrl
    import bist_pkg::*;
#(
    parameter int               PAT_W = 2,
    parameter int               RSP_W = 1,
    parameter int               NPAT  = 255,
    parameter logic [LFSR_W-1:0] SEED = 8'h01
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [SIG_W-1:0] EXP_SIG,
    input  logic [RSP_W-1:0] RSP,
    output logic [PAT_W-1:0] PAT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG
);

    if (NPAT < 1 || NPAT > 65535) begin : g_bad_npat
        $error("cell_bist_ctrl: NPAT must be in 1..65535");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("cell_bist_ctrl: SEED must be non-zero");
    end
    if (PAT_W < 1 || PAT_W > LFSR_W || RSP_W < 1 || RSP_W > SIG_W) begin : g_bad_width
        $error("cell_bist_ctrl: PAT_W or RSP_W out of range");
    end

    bist_state_e       state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [15:0]       count_q;
    logic              pass_q;
    logic              misr_clear;
    logic              misr_en;
    logic              last_pat;
    logic [SIG_W-1:0]  sig_next;

    assign last_pat = (count_q == 16'(NPAT - 1));

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            ST_IDLE: if (START) state_d = ST_SEED;
            ST_SEED: begin
                misr_clear = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                misr_en = 1'b1;
                if (last_pat) state_d = ST_DONE;
            end
            ST_DONE: if (START) state_d = ST_SEED;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_SEED: begin
                    lfsr_q  <= SEED;
                    count_q <= '0;
                    pass_q  <= 1'b0;
                end
                ST_RUN: begin
                    lfsr_q  <= lfsr_step(lfsr_q);
                    count_q <= count_q + 16'd1;
                    // Judge the signature that includes this cycle's response.
                    if (last_pat) pass_q <= (sig_next == EXP_SIG);
                end
                default: ;
            endcase
        end
    end

    bist_misr #(
        .RSP_W (RSP_W)
    ) u_misr (
        .clk      (CLK),
        .rst      (RST),
        .clear    (misr_clear),
        .enable   (misr_en),
        .rsp      (RSP),
        .sig      (SIG),
        .sig_next (sig_next)
    );

    assign PAT  = lfsr_q[PAT_W-1:0];
    assign BUSY = (state_q == ST_SEED) || (state_q == ST_RUN);
    assign DONE = (state_q == ST_DONE);
    assign PASS = pass_q;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Randomised bench for cell_bist_ctrl: three instances (NPAT 5, 255, 1) driven by
// random cell truth tables and checked cycle by cycle against a sequence model.
module tb_cell_bist_ctrl;

    localparam int NI = 3;
    localparam int NPAT_A = 5, NPAT_B = 255, NPAT_C = 1;
    localparam logic [7:0] SEED_A = 8'h01, SEED_B = 8'hC3, SEED_C = 8'h5A;

    int npat_of [NI] = '{NPAT_A, NPAT_B, NPAT_C};
    int seed_of [NI] = '{SEED_A, SEED_B, SEED_C};
    int patw_of [NI] = '{2, 8, 3};
    int rspw_of [NI] = '{1, 16, 4};

    logic CLK = 1'b0;
    logic RST;
    logic START;
    logic [15:0] exp_sig [NI];

    logic [1:0]  pat_a;  logic [0:0]  rsp_a;
    logic [7:0]  pat_b;  logic [15:0] rsp_b;
    logic [2:0]  pat_c;  logic [3:0]  rsp_c;
    logic [NI-1:0] busy, done, pass;
    logic [15:0] sig [NI];

    // Cell truth tables, indexed by pattern; changed only between runs.
    int tt [NI][256];

    assign rsp_a = 1'(tt[0][pat_a]);
    assign rsp_b = 16'(tt[1][pat_b]);
    assign rsp_c = 4'(tt[2][pat_c]);

    cell_bist_ctrl #(.PAT_W(2), .RSP_W(1), .NPAT(NPAT_A), .SEED(SEED_A)) u_a (
        .CLK(CLK), .RST(RST), .START(START), .EXP_SIG(exp_sig[0]), .RSP(rsp_a),
        .PAT(pat_a), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .SIG(sig[0]));
    cell_bist_ctrl #(.PAT_W(8), .RSP_W(16), .NPAT(NPAT_B), .SEED(SEED_B)) u_b (
        .CLK(CLK), .RST(RST), .START(START), .EXP_SIG(exp_sig[1]), .RSP(rsp_b),
        .PAT(pat_b), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .SIG(sig[1]));
    cell_bist_ctrl #(.PAT_W(3), .RSP_W(4), .NPAT(NPAT_C), .SEED(SEED_C)) u_c (
        .CLK(CLK), .RST(RST), .START(START), .EXP_SIG(exp_sig[2]), .RSP(rsp_c),
        .PAT(pat_c), .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .SIG(sig[2]));

    logic [31:0] o_pat [NI];
    always_comb begin
        o_pat[0] = 32'(pat_a);
        o_pat[1] = 32'(pat_b);
        o_pat[2] = 32'(pat_c);
    end

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Reference: the stimulus is the x^8+x^6+x^5+x^4+1 sequence from the seed, the
    // signature is the CRC-style polynomial division of the response stream.
    int mpat [NI][0:NPAT_B];
    int msig [NI][0:NPAT_B];
    bit want_pass [NI];

    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) & 'hFF) | fb;
    endfunction

    function automatic int misr_next(input int m, input int r);
        int n;
        n = (m << 1) & 'hFFFF;
        if ((m & 'h8000) != 0) n = n ^ 'h1021;
        return n ^ r;
    endfunction

    task automatic build_model(input int id);
        int l, m;
        l = seed_of[id];
        m = 0;
        for (int k = 0; k <= npat_of[id]; k++) begin
            mpat[id][k] = l & ((1 << patw_of[id]) - 1);
            msig[id][k] = m;
            if (k < npat_of[id]) begin
                m = misr_next(m, tt[id][mpat[id][k]] & ((1 << rspw_of[id]) - 1));
                l = lfsr_next(l);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        for (int id = 0; id < NI; id++) begin
            check($sformatf("%s pat[%0d]", tag, id), o_pat[id], 32'(seed_of[id] & ((1 << patw_of[id]) - 1)));
            check($sformatf("%s busy[%0d]", tag, id), 32'(busy[id]), 0);
            check($sformatf("%s done[%0d]", tag, id), 32'(done[id]), 0);
            check($sformatf("%s pass[%0d]", tag, id), 32'(pass[id]), 0);
            check($sformatf("%s sig[%0d]", tag, id), 32'(sig[id]), 0);
        end
    endtask

    // One complete run, starting from IDLE or DONE. Called just after a negedge.
    task automatic run(input bit directed);
        int k;
        for (int id = 0; id < NI; id++) begin
            for (int p = 0; p < 256; p++) begin
                if (directed) tt[id][p] = (id == 0) ? ((p == 3) ? 1 : 0) : ((id == 1) ? 0 : 'hF);
                else          tt[id][p] = int'($urandom_range(0, 65535));
            end
            build_model(id);
            want_pass[id] = directed ? 1'b1 : 1'($urandom_range(0, 1));
            exp_sig[id] = want_pass[id] ? 16'(msig[id][npat_of[id]])
                                        : 16'(msig[id][npat_of[id]]) ^ 16'($urandom_range(1, 65535));
        end
        START = 1'b1;
        for (int t = 1; t <= NPAT_B + 3; t++) begin
            @(negedge CLK);
            for (int id = 0; id < NI; id++) begin
                check($sformatf("busy[%0d] t=%0d", id, t), 32'(busy[id]), 32'(t <= npat_of[id] + 1));
                check($sformatf("done[%0d] t=%0d", id, t), 32'(done[id]), 32'(t >= npat_of[id] + 2));
                if (t >= 2) begin
                    k = (t - 2 < npat_of[id]) ? t - 2 : npat_of[id];
                    check($sformatf("pat[%0d] t=%0d", id, t), o_pat[id], 32'(mpat[id][k]));
                    check($sformatf("sig[%0d] t=%0d", id, t), 32'(sig[id]), 32'(msig[id][k]));
                    check($sformatf("pass[%0d] t=%0d", id, t), 32'(pass[id]),
                          (t >= npat_of[id] + 2) ? 32'(want_pass[id]) : 0);
                end
            end
            // Random START while every instance is still in SEED or RUN: must be ignored.
            START = (t <= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        for (int id = 0; id < NI; id++) exp_sig[id] = '0;
        for (int id = 0; id < NI; id++)
            for (int p = 0; p < 256; p++) tt[id][p] = 0;

        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_reset("reset");
        repeat (3) @(negedge CLK);
        check_reset("idle hold");

        run(1'b1);
        for (int i = 0; i < 4; i++) run(1'b0);

        // Abort on the third RUN cycle of the NPAT=5 instance.
        START = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_reset("abort");
        run(1'b0);

        // START held in DONE: each instance restarts every NPAT+2 cycles.
        START = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            @(negedge CLK);
            for (int id = 0; id < NI; id++) begin
                check($sformatf("held done[%0d] t=%0d", id, t), 32'(done[id]),
                      32'((t % (npat_of[id] + 2)) == 0));
                check($sformatf("held busy[%0d] t=%0d", id, t), 32'(busy[id]),
                      32'((t % (npat_of[id] + 2)) != 0));
            end
        end
        START = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cell_bist_ctrl.md
Name: cell_bist_ctrl

Overview:
Built-in self-test controller for one combinational standard cell or a small cell array in the characterisation flow, such as a two-input gate.
- Upstream: an 8-bit LFSR drives the cell inputs with pseudo-random stimulus.
- Downstream: a 16-bit MISR compacts the cell outputs.
- A small FSM sequences seed, run and done, then compares the final signature against an expected value.
- Sits between the test-access logic (START/EXP_SIG) and the cell-under-test wrapper.

Parameters:
PAT_W, 2, stimulus bits driven to the cell (taken from LFSR[PAT_W-1:0]); 1..8
RSP_W, 1, response bits captured from the cell; 1..16
NPAT, 255, patterns applied per run; 1..65535; 0 is an elaboration error
SEED, 8'h01, LFSR seed; must be non-zero, elaboration error otherwise

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  run request, sampled only in IDLE and DONE
EXP_SIG  input  16  expected signature, sampled when entering DONE
RSP  input  RSP_W  cell response, combinational function of PAT
PAT  output  PAT_W  registered stimulus to the cell
BUSY  output  1  high in SEED and RUN
DONE  output  1  high in DONE
PASS  output  1  valid while DONE; SIG equals EXP_SIG
SIG  output  16  current MISR contents

Behaviour:
- One clock; reset is synchronous and active-high on RST.
- Reset values: state=IDLE, LFSR=SEED, MISR=0, count=0; outputs PAT=SEED[PAT_W-1:0], BUSY=0, DONE=0, PASS=0, SIG=0.
- RST asserted mid-run aborts the run immediately and restores reset values; no partial DONE is produced.
- LFSR: Fibonacci, shift left, fb = L[7]^L[5]^L[4]^L[3] (x^8+x^6+x^5+x^4+1, maximal, period 255). next = {L[6:0], fb}. PAT = L[PAT_W-1:0].
- MISR: 16-bit, poly 16'h1021. next = {M[14:0],1'b0} ^ (M[15] ? 16'h1021 : 0) ^ zero_ext(RSP).
- count: 16-bit pattern counter.
- States and transitions:
  - IDLE: START=1 -> SEED.
  - SEED (1 cycle): LFSR<=SEED, MISR<=0, count<=0, PASS<=0 -> RUN.
  - RUN: every cycle, MISR absorbs RSP for the current PAT, LFSR advances, count++. When count==NPAT-1 on that edge -> DONE.
  - DONE: PASS<=(MISR_next==EXP_SIG), computed on the transition edge. Hold LFSR, MISR and PASS. START=1 -> SEED (restart).
- START while in SEED/RUN is ignored; START held high in DONE restarts every time DONE is reached.
- Latency: START edge to DONE=1 is NPAT+2 cycles. BUSY is high for exactly NPAT+1 cycles.
- Exactly NPAT responses are compacted; the response to the pattern present in the last RUN cycle is included.
- For NPAT>255 the LFSR wraps through its period; no special handling.

Decomposition:
- Shared package bist_pkg:
  - state enum {IDLE, SEED, RUN, DONE}
  - LFSR_W=8, SIG_W=16
  - MISR_POLY=16'h1021, LFSR_TAPS=8'hB8
- One natural sub-module: bist_misr, a 16-bit MISR with load-clear/enable and polynomial from the package, reusable for other cell arrays.
- The LFSR stays inline.

Test Plan:
1. Reset: RST=1 for 2 cycles, then 0 -> PAT=2'b01, BUSY=0, DONE=0, PASS=0, SIG=16'h0000.
2. NPAT=5, RSP driven by AND(PAT[0],PAT[1]) -> PAT sequence 01,10,00,00,01; LFSR 01,02,04,08,11; DONE at cycle 7 after START; BUSY high 6 cycles.
3. NPAT=2, RSP tied 1, EXP_SIG=16'h0003 -> SIG=0001 then 0003; DONE=1, PASS=1. Repeat with EXP_SIG=16'h0004 -> PASS=0.
4. NPAT=255, RSP tied 0 -> SIG=0000; LFSR back to 8'h01 at DONE; EXP_SIG=0 -> PASS=1.
5. RST pulsed at the 3rd RUN cycle of an NPAT=10 run -> all outputs at reset values next cycle; a new START gives a SIG identical to an uninterrupted run.
6. START pulsed during RUN is ignored (same DONE time); START in DONE restarts, with PASS cleared in SEED and BUSY reasserted.
